// File: rtl/tt_ovi_issue_buffer.sv
// Speculative OVI issue buffer: holds issued vector instructions, promotes them to senior in order,
// kills non-senior entries and returns one credit per freed slot. Optional checks: TT_OVI_ISSUE_BUF_CHECK_EN.
module tt_ovi_issue_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic [31:0] issue_inst,
  input  logic [4:0]  issue_sb_id,
  input  logic [63:0] issue_scalar_opnd,
  input  logic [39:0] issue_vcsr,
  input  logic        issue_vcsr_lmulb2,
  output logic        issue_credit,
  input  logic [4:0]  dispatch_sb_id,
  input  logic        dispatch_next_senior,
  input  logic        dispatch_kill,
  input  logic        read_req,
  output logic        read_valid,
  output logic [31:0] read_issue_inst,
  output logic [4:0]  read_issue_sb_id,
  output logic [63:0] read_issue_scalar_opnd,
  output logic [39:0] read_issue_vcsr,
  output logic        read_issue_vcsr_lmulb2,
  output logic        protocol_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  sb_id;
    logic [63:0] scalar_opnd;
    logic [39:0] vcsr;
    logic        vcsr_lmulb2;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_sptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_pend_cr;
  logic          r_issue_credit;

  logic [PW-1:0] w_rptr_next;
  logic [PW-1:0] w_sptr_next;
  logic [PW-1:0] w_wptr_next;
  logic [CW-1:0] w_pend_cr_next;
  logic [PW-1:0] w_killed;
  logic          w_pop;
  logic          w_promote;
  logic          w_full;
  logic          w_write;
  logic          w_kill_drop;
  entry_t        w_wr_entry;
  entry_t        w_head;

  assign w_wr_entry = '{
    inst:        issue_inst,
    sb_id:       issue_sb_id,
    scalar_opnd: issue_scalar_opnd,
    vcsr:        issue_vcsr,
    vcsr_lmulb2: issue_vcsr_lmulb2
  };

  // Events resolve in the order pop, promote, kill, write; each stage sees the previous one's pointers.
  always_comb begin
    w_pop       = read_req && (r_rptr != r_sptr);
    w_rptr_next = r_rptr + PW'(w_pop);

    w_promote   = dispatch_next_senior && (r_sptr != r_wptr);
    w_sptr_next = r_sptr + PW'(w_promote);

    w_killed    = dispatch_kill ? (r_wptr - w_sptr_next) : '0;
    w_kill_drop = issue_valid && dispatch_kill;

    w_full      = ((r_wptr - w_rptr_next) == PW'(DEPTH));
    w_write     = issue_valid && !dispatch_kill && !w_full;

    if (dispatch_kill) begin
      w_wptr_next = w_sptr_next;
    end else begin
      w_wptr_next = r_wptr + PW'(w_write);
    end

    w_pend_cr_next = r_pend_cr + CW'(w_pop) + CW'(w_killed) + CW'(w_kill_drop)
                     - CW'(r_issue_credit);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rptr         <= '0;
      r_sptr         <= '0;
      r_wptr         <= '0;
      r_pend_cr      <= '0;
      r_issue_credit <= 1'b0;
    end else begin
      r_rptr         <= w_rptr_next;
      r_sptr         <= w_sptr_next;
      r_wptr         <= w_wptr_next;
      r_pend_cr      <= w_pend_cr_next;
      // Looking at the next count gives a one-cycle pop/kill-to-credit latency.
      r_issue_credit <= (w_pend_cr_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_write) begin
      r_mem[r_wptr[AW-1:0]] <= w_wr_entry;
    end
  end

  assign w_head                 = r_mem[r_rptr[AW-1:0]];
  assign issue_credit           = r_issue_credit;
  assign read_valid             = (r_rptr != r_sptr);
  assign read_issue_inst        = w_head.inst;
  assign read_issue_sb_id       = w_head.sb_id;
  assign read_issue_scalar_opnd = w_head.scalar_opnd;
  assign read_issue_vcsr        = w_head.vcsr;
  assign read_issue_vcsr_lmulb2 = w_head.vcsr_lmulb2;

`ifdef TT_OVI_ISSUE_BUF_CHECK_EN
  logic r_protocol_err;
  logic w_overflow;
  logic w_promote_empty;
  logic w_sb_mismatch;

  assign w_overflow      = issue_valid && !dispatch_kill && w_full;
  assign w_promote_empty = dispatch_next_senior && (r_sptr == r_wptr);
  assign w_sb_mismatch   = w_promote && (r_mem[r_sptr[AW-1:0]].sb_id != dispatch_sb_id);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_protocol_err <= 1'b0;
    end else if (w_overflow || w_promote_empty || w_sb_mismatch) begin
      r_protocol_err <= 1'b1;
    end
  end

  assign protocol_err = r_protocol_err;
`else
  logic w_unused_sb_id;
  assign w_unused_sb_id = &{1'b0, dispatch_sb_id};
  assign protocol_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tt_ovi_issue_buffer.sv
// Self-checking bench for tt_ovi_issue_buffer: directed scenarios plus randomized traffic
// compared against a queue-based model of senior/non-senior entries and owed credits.
module tb_tt_ovi_issue_buffer;
  localparam int DEPTH = 16;

`ifdef TT_OVI_ISSUE_BUF_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic [31:0] issue_inst;
  logic [4:0]  issue_sb_id;
  logic [63:0] issue_scalar_opnd;
  logic [39:0] issue_vcsr;
  logic        issue_vcsr_lmulb2;
  logic        issue_credit;
  logic [4:0]  dispatch_sb_id;
  logic        dispatch_next_senior;
  logic        dispatch_kill;
  logic        read_req;
  logic        read_valid;
  logic [31:0] read_issue_inst;
  logic [4:0]  read_issue_sb_id;
  logic [63:0] read_issue_scalar_opnd;
  logic [39:0] read_issue_vcsr;
  logic        read_issue_vcsr_lmulb2;
  logic        protocol_err;

  always #5 clk = ~clk;

  tt_ovi_issue_buffer #(.DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .issue_valid            (issue_valid),
    .issue_inst             (issue_inst),
    .issue_sb_id            (issue_sb_id),
    .issue_scalar_opnd      (issue_scalar_opnd),
    .issue_vcsr             (issue_vcsr),
    .issue_vcsr_lmulb2      (issue_vcsr_lmulb2),
    .issue_credit           (issue_credit),
    .dispatch_sb_id         (dispatch_sb_id),
    .dispatch_next_senior   (dispatch_next_senior),
    .dispatch_kill          (dispatch_kill),
    .read_req               (read_req),
    .read_valid             (read_valid),
    .read_issue_inst        (read_issue_inst),
    .read_issue_sb_id       (read_issue_sb_id),
    .read_issue_scalar_opnd (read_issue_scalar_opnd),
    .read_issue_vcsr        (read_issue_vcsr),
    .read_issue_vcsr_lmulb2 (read_issue_vcsr_lmulb2),
    .protocol_err           (protocol_err)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  sb;
    logic [63:0] opnd;
    logic [39:0] vcsr;
    logic        lmul;
  } ent_t;

  // Model: queue holds live entries oldest first; the first m_sen of them are senior.
  ent_t mq[$];
  int   m_sen;
  int   m_owed;
  bit   m_credit;
  bit   m_err;
  int   credits_seen;
  int   n_checks;
  int   n_fail;

  function automatic ent_t dut_head();
    return {read_issue_inst, read_issue_sb_id, read_issue_scalar_opnd, read_issue_vcsr,
            read_issue_vcsr_lmulb2};
  endfunction

  task automatic idle();
    reset_n              = 1'b1;
    issue_valid          = 1'b0;
    dispatch_next_senior = 1'b0;
    dispatch_kill        = 1'b0;
    read_req             = 1'b0;
    dispatch_sb_id       = '0;
  endtask

  task automatic set_issue(input logic [4:0] sb);
    issue_valid       = 1'b1;
    issue_sb_id       = sb;
    issue_inst        = $urandom;
    issue_scalar_opnd = {$urandom, $urandom};
    issue_vcsr        = {8'($urandom), $urandom};
    issue_vcsr_lmulb2 = 1'($urandom);
  endtask

  // Advance the model by the current inputs, then clock the DUT and sample just after the edge.
  task automatic step();
    ent_t e;
    int   killed;
    bit   pop;
    if (!reset_n) begin
      mq.delete();
      m_sen = 0; m_owed = 0; m_credit = 0; m_err = 0;
    end else begin
      pop = read_req && (m_sen > 0);
      if (pop) begin
        void'(mq.pop_front());
        m_sen--;
      end
      if (dispatch_next_senior) begin
        if (m_sen < mq.size()) begin
          if (mq[m_sen].sb != dispatch_sb_id) m_err = 1;
          m_sen++;
        end else begin
          m_err = 1;
        end
      end
      killed = 0;
      if (dispatch_kill) begin
        killed = mq.size() - m_sen;
        while (mq.size() > m_sen) void'(mq.pop_back());
        if (issue_valid) killed++;
      end else if (issue_valid) begin
        e = {issue_inst, issue_sb_id, issue_scalar_opnd, issue_vcsr, issue_vcsr_lmulb2};
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_err = 1;
      end
      m_owed   = m_owed + int'(pop) + killed - int'(m_credit);
      m_credit = (m_owed != 0);
    end
    @(posedge clk);
    #1;
    if (issue_credit === 1'b1) credits_seen++;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    step();
    step();
    idle();
    n_checks++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL reset_read_valid got %b want 0", read_valid); end
    n_checks++; if (issue_credit !== 1'b0) begin n_fail++; $display("FAIL reset_credit got %b want 0", issue_credit); end
    n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", protocol_err); end
    n_checks++; if (dut_head() !== '0) begin n_fail++; $display("FAIL reset_fields got %h want 0", dut_head()); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    ent_t e3;
    do_reset();
    credits_seen = 0;
    set_issue(5'd3); e3 = {issue_inst, issue_sb_id, issue_scalar_opnd, issue_vcsr, issue_vcsr_lmulb2};
    step(); idle();
    set_issue(5'd4); step(); idle();
    n_checks++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL basic_prepromote_valid got %b want 0", read_valid); end
    dispatch_next_senior = 1'b1; dispatch_sb_id = 5'd3;
    step(); idle();
    n_checks++; if (read_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", read_valid); end
    n_checks++; if (read_issue_sb_id !== 5'd3) begin n_fail++; $display("FAIL basic_sb got %0d want 3", read_issue_sb_id); end
    n_checks++; if (dut_head() !== e3) begin n_fail++; $display("FAIL basic_fields got %h want %h", dut_head(), e3); end
    read_req = 1'b1;
    step();
    n_checks++; if (issue_credit !== 1'b1) begin n_fail++; $display("FAIL basic_credit got %b want 1", issue_credit); end
    n_checks++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL basic_sb4_hidden got %b want 0", read_valid); end
    step();
    n_checks++; if (issue_credit !== 1'b0) begin n_fail++; $display("FAIL basic_credit_end got %b want 0", issue_credit); end
    n_checks++; if (credits_seen !== 1) begin n_fail++; $display("FAIL basic_credit_count got %0d want 1", credits_seen); end
    idle();
    $display("test_basic done");
  endtask

  task automatic test_kill();
    ent_t saved[5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_issue(5'(10 + i));
      saved[i] = {issue_inst, issue_sb_id, issue_scalar_opnd, issue_vcsr, issue_vcsr_lmulb2};
      step(); idle();
    end
    for (int i = 0; i < 2; i++) begin
      dispatch_next_senior = 1'b1; dispatch_sb_id = saved[i].sb;
      step(); idle();
    end
    credits_seen = 0;
    dispatch_kill = 1'b1;
    step(); idle();
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (issue_credit !== 1'b1) begin n_fail++; $display("FAIL kill_pulse%0d got %b want 1", k, issue_credit); end
      step();
    end
    n_checks++; if (issue_credit !== 1'b0) begin n_fail++; $display("FAIL kill_pulse_end got %b want 0", issue_credit); end
    n_checks++; if (credits_seen !== 3) begin n_fail++; $display("FAIL kill_credit_count got %0d want 3", credits_seen); end
    n_checks++; if (read_valid !== 1'b1 || dut_head() !== saved[0]) begin n_fail++; $display("FAIL kill_senior0 valid %b got %h want %h", read_valid, dut_head(), saved[0]); end
    read_req = 1'b1;
    step();
    n_checks++; if (read_valid !== 1'b1 || dut_head() !== saved[1]) begin n_fail++; $display("FAIL kill_senior1 valid %b got %h want %h", read_valid, dut_head(), saved[1]); end
    step(); idle();
    n_checks++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL kill_empty got %b want 0", read_valid); end
    step(); step();
    n_checks++; if (credits_seen !== 5) begin n_fail++; $display("FAIL kill_total_credits got %0d want 5", credits_seen); end
    $display("test_kill done");
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_issue(5'(20 + i)); step(); idle();
    end
    credits_seen = 0;
    dispatch_next_senior = 1'b1; dispatch_sb_id = 5'd20; dispatch_kill = 1'b1;
    set_issue(5'd23);
    step(); idle();
    n_checks++; if (read_valid !== 1'b1 || read_issue_sb_id !== 5'd20) begin n_fail++; $display("FAIL same_promoted valid %b sb %0d want 1/20", read_valid, read_issue_sb_id); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (issue_credit !== 1'b1) begin n_fail++; $display("FAIL same_pulse%0d got %b want 1", k, issue_credit); end
      step();
    end
    n_checks++; if (issue_credit !== 1'b0 || credits_seen !== 3) begin n_fail++; $display("FAIL same_credit_total credit %b count %0d want 0/3", issue_credit, credits_seen); end
    read_req = 1'b1;
    step(); idle();
    n_checks++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL same_one_entry got %b want 0", read_valid); end
    $display("test_same_cycle done");
  endtask

  task automatic test_overflow_wrap();
    int issued, popped, cyc;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_issue(5'(i)); step(); idle();
    end
    set_issue(5'd31); step(); idle();
    n_checks++; if (protocol_err !== (CHK && m_err)) begin n_fail++; $display("FAIL overflow_err got %b want %b", protocol_err, CHK && m_err); end
    while (m_sen < mq.size()) begin
      dispatch_next_senior = 1'b1; dispatch_sb_id = mq[m_sen].sb;
      step(); idle();
    end
    for (int j = 0; j < DEPTH; j++) begin
      n_checks++; if (read_valid !== 1'b1 || read_issue_sb_id !== 5'(j)) begin n_fail++; $display("FAIL full_order%0d valid %b sb %0d want 1/%0d", j, read_valid, read_issue_sb_id, j); end
      read_req = 1'b1; step(); idle();
    end
    n_checks++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL overflow_dropped got %b want 0", read_valid); end
    issued = 0; popped = 0; cyc = 0;
    while (popped < 40 && cyc < 2000) begin
      idle();
      if (issued < 40 && mq.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        set_issue(5'(issued));
        issue_inst = 32'(issued);
        issued++;
      end
      if (m_sen < mq.size() && $urandom_range(0, 1) == 1) begin
        dispatch_next_senior = 1'b1; dispatch_sb_id = mq[m_sen].sb;
      end
      if ($urandom_range(0, 2) != 0) read_req = 1'b1;
      if (read_req && read_valid) begin
        n_checks++; if (read_issue_inst !== 32'(popped)) begin n_fail++; $display("FAIL wrap_order got %0d want %0d", read_issue_inst, popped); end
        popped++;
      end
      step();
      cyc++;
    end
    idle();
    n_checks++; if (popped !== 40) begin n_fail++; $display("FAIL wrap_timeout popped %0d want 40", popped); end
    $display("test_overflow_wrap done");
  endtask

  task automatic test_sb_mismatch();
    do_reset();
    set_issue(5'd6); step(); idle();
    dispatch_next_senior = 1'b1; dispatch_sb_id = 5'd7;
    step(); idle();
    n_checks++; if (protocol_err !== (CHK && m_err)) begin n_fail++; $display("FAIL mismatch_err got %b want %b", protocol_err, CHK && m_err); end
    n_checks++; if (read_valid !== 1'b1 || read_issue_sb_id !== 5'd6) begin n_fail++; $display("FAIL mismatch_advance valid %b sb %0d want 1/6", read_valid, read_issue_sb_id); end
    $display("test_sb_mismatch done");
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1) set_issue(5'($urandom));
      if ($urandom_range(0, 9) < 3) begin
        dispatch_next_senior = 1'b1;
        if (m_sen < mq.size() && $urandom_range(0, 7) != 0) dispatch_sb_id = mq[m_sen].sb;
        else dispatch_sb_id = 5'($urandom);
      end
      if ($urandom_range(0, 19) == 0) dispatch_kill = 1'b1;
      if ($urandom_range(0, 1) == 1) read_req = 1'b1;
      step();
      n_checks++; if (read_valid !== (m_sen > 0)) begin n_fail++; $display("FAIL rand_valid cyc %0d got %b want %b", c, read_valid, m_sen > 0); end
      n_checks++; if (issue_credit !== m_credit) begin n_fail++; $display("FAIL rand_credit cyc %0d got %b want %b", c, issue_credit, m_credit); end
      n_checks++; if (protocol_err !== (CHK && m_err)) begin n_fail++; $display("FAIL rand_err cyc %0d got %b want %b", c, protocol_err, CHK && m_err); end
      if (m_sen > 0) begin
        n_checks++; if (dut_head() !== mq[0]) begin n_fail++; $display("FAIL rand_head cyc %0d got %h want %h", c, dut_head(), mq[0]); end
      end
    end
    idle();
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_issue(5'(i)); step(); idle();
    end
    for (int i = 0; i < 8; i++) begin
      dispatch_next_senior = 1'b1; dispatch_sb_id = 5'(i);
      step(); idle();
    end
    dispatch_kill = 1'b1; step(); idle();
    reset_n = 1'b0; step(); idle();
    n_checks++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", read_valid); end
    n_checks++; if (issue_credit !== 1'b0) begin n_fail++; $display("FAIL midreset_credit got %b want 0", issue_credit); end
    n_checks++; if (dut_head() !== '0) begin n_fail++; $display("FAIL midreset_fields got %h want 0", dut_head()); end
    credits_seen = 0;
    for (int i = 0; i < 6; i++) step();
    n_checks++; if (credits_seen !== 0) begin n_fail++; $display("FAIL midreset_residual got %0d want 0", credits_seen); end
    n_checks++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_stay_empty got %b want 0", read_valid); end
    $display("test_reset_mid done");
  endtask

  initial begin
    n_checks = 0; n_fail = 0; credits_seen = 0;
    m_sen = 0; m_owed = 0; m_credit = 0; m_err = 0;
    issue_inst = '0; issue_sb_id = '0; issue_scalar_opnd = '0; issue_vcsr = '0; issue_vcsr_lmulb2 = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_kill();
    test_same_cycle();
    test_overflow_wrap();
    test_sb_mismatch();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
